// File: rtl/display_hex_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_hex_tx_pkg
// Description : Shared types and ASCII constants for the display hex
//               transmitter (frame state encoding, CR/LF, digit bases,
//               "0x" prefix bytes).
// Revision    : 1.0 - initial release
// ============================================================================
package display_hex_tx_pkg;

    // Frame sequencer states; the prefix states exist only in prefix builds.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PFX0  = 3'd1,
        ST_PFX1  = 3'd2,
        ST_DIGIT = 3'd3,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5
    } state_t;

    localparam logic [7:0] c_ASCII_CR          = 8'h0D;
    localparam logic [7:0] c_ASCII_LF          = 8'h0A;
    localparam logic [7:0] c_ASCII_DIGIT_BASE  = 8'h30;
    // 'A' (0x41) minus 10, so a nibble value of 10..15 maps straight to A..F.
    localparam logic [7:0] c_ASCII_LETTER_BASE = 8'h37;
    localparam logic [7:0] c_ASCII_PFX0        = 8'h30;
    localparam logic [7:0] c_ASCII_PFX1        = 8'h78;

endpackage
`default_nettype wire

// File: rtl/hex_nibble_ascii.sv
`default_nettype none
// ============================================================================
// Module      : hex_nibble_ascii
// Description : Combinational 4-bit nibble to uppercase ASCII hex character.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_nibble_ascii
    import display_hex_tx_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_ascii
);

    // 0-9 offset from '0', 10-15 offset from the letter base so they land on A-F.
    always_comb begin
        if (i_nib < 4'd10) begin
            o_ascii = c_ASCII_DIGIT_BASE + {4'h0, i_nib};
        end else begin
            o_ascii = c_ASCII_LETTER_BASE + {4'h0, i_nib};
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_hex_tx.sv
`default_nettype none
// ============================================================================
// Module      : display_hex_tx
// Description : Snapshots the processor display value and writes it as an
//               ASCII hex line ("1A2F\r\n") into a UART TX FIFO write port.
//               Optional build macro DISPLAY_HEX_PREFIX_EN adds a "0x" prefix.
// Revision    : 1.0 - initial release
// ============================================================================
module display_hex_tx
    import display_hex_tx_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] display_in,
    input  logic              send,
    input  logic              auto_en,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic              busy
);

    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] c_IDX_TOP = IDX_W'(NIB - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   snap_q, snap_d;
    logic [DATA_W-1:0]   last_sent_q, last_sent_d;
    logic                pending_q, pending_d;

    logic                w_busy;
    logic                w_accept;
    logic                w_req;
    logic [DATA_W-1:0]   w_cmp_ref;
    logic [3:0]          w_nib;
    logic [7:0]          w_digit;

    assign w_busy   = (state_q != ST_IDLE);
    assign w_accept = w_busy && clk_en && !tx_full;
    assign busy     = w_busy;
    assign wr_uart  = w_accept;

    // While a frame is out, the snapshot is what will become the last sent
    // value, so auto-change detection compares against it; otherwise a frame
    // triggered by a change would immediately re-request itself.
    assign w_cmp_ref = w_busy ? snap_q : last_sent_q;
    assign w_req     = send || (auto_en && (display_in != w_cmp_ref));

    // Select the nibble currently being emitted from the snapshot.
    always_comb begin
        w_nib = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_nib = snap_q[i*4 +: 4];
            end
        end
    end

    hex_nibble_ascii u_nib (
        .i_nib   (w_nib),
        .o_ascii (w_digit)
    );

    // Byte presented to the FIFO, a pure function of state, index and snapshot.
    always_comb begin
        case (state_q)
`ifdef DISPLAY_HEX_PREFIX_EN
            ST_PFX0:  w_data = c_ASCII_PFX0;
            ST_PFX1:  w_data = c_ASCII_PFX1;
`endif
            ST_DIGIT: w_data = w_digit;
            ST_CR:    w_data = c_ASCII_CR;
            ST_LF:    w_data = c_ASCII_LF;
            default:  w_data = 8'h00;
        endcase
    end

    // Next-state: start frames from IDLE, advance one byte per accepted strobe,
    // and fold any request seen mid-frame into a single pending flag.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        last_sent_d = last_sent_q;
        pending_d   = pending_q;

        if (clk_en && w_busy && w_req) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clk_en && (w_req || pending_q)) begin
                    snap_d    = display_in;
                    pending_d = 1'b0;
`ifdef DISPLAY_HEX_PREFIX_EN
                    state_d   = ST_PFX0;
`else
                    state_d   = ST_DIGIT;
                    idx_d     = c_IDX_TOP;
`endif
                end
            end
`ifdef DISPLAY_HEX_PREFIX_EN
            ST_PFX0: begin
                if (w_accept) state_d = ST_PFX1;
            end
            ST_PFX1: begin
                if (w_accept) begin
                    state_d = ST_DIGIT;
                    idx_d   = c_IDX_TOP;
                end
            end
`endif
            ST_DIGIT: begin
                if (w_accept) begin
                    if (idx_q == '0) begin
                        state_d = ST_CR;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            ST_CR: begin
                if (w_accept) state_d = ST_LF;
            end
            ST_LF: begin
                if (w_accept) begin
                    state_d     = ST_IDLE;
                    last_sent_d = snap_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and data registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            last_sent_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            last_sent_q <= last_sent_d;
            pending_q   <= pending_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_hex_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_hex_tx
// Description : Self-checking bench for display_hex_tx. A frame-level model
//               (byte queue per frame) predicts wr_uart/w_data/busy each
//               cycle under directed and random stimulus. Honours the
//               DISPLAY_HEX_PREFIX_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_hex_tx;

    localparam int DATA_W = 16;
    localparam int NIB    = DATA_W / 4;
`ifdef DISPLAY_HEX_PREFIX_EN
    localparam int FRAME_LEN = NIB + 4;
`else
    localparam int FRAME_LEN = NIB + 2;
`endif

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              clk_en     = 1'b0;
    logic [DATA_W-1:0] display_in = '0;
    logic              send       = 1'b0;
    logic              auto_en    = 1'b0;
    logic              tx_full    = 1'b0;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic              busy;

    display_hex_tx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .display_in (display_in),
        .send       (send),
        .auto_en    (auto_en),
        .tx_full    (tx_full),
        .w_data     (w_data),
        .wr_uart    (wr_uart),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int n_strobe = 0;

    // Reference model: bytes still to be sent in the current frame.
    logic [7:0]        m_q[$];
    logic [DATA_W-1:0] m_last = '0;
    logic [DATA_W-1:0] m_snap = '0;
    bit                m_pend = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    function automatic void build_frame(input logic [DATA_W-1:0] v);
        m_q.delete();
`ifdef DISPLAY_HEX_PREFIX_EN
        m_q.push_back(8'h30);
        m_q.push_back(8'h78);
`endif
        for (int i = NIB - 1; i >= 0; i--) m_q.push_back(hex_char(v[i*4 +: 4]));
        m_q.push_back(8'h0D);
        m_q.push_back(8'h0A);
    endfunction

    // One clock: check outputs mid-cycle, then advance the model as the DUT
    // will at the coming rising edge with the inputs now applied.
    task automatic step();
        logic       e_busy;
        logic       e_wr;
        logic [7:0] e_data;
        @(negedge clk);
        if (!reset_n) begin
            m_q.delete();
            m_pend = 1'b0;
            m_last = '0;
            m_snap = '0;
        end
        e_busy = (m_q.size() != 0);
        e_wr   = e_busy && clk_en && !tx_full;
        e_data = e_busy ? m_q[0] : 8'h00;
        check_value("wr_uart", {31'b0, wr_uart}, {31'b0, e_wr});
        check_value("w_data",  {24'b0, w_data},  {24'b0, e_data});
        check_value("busy",    {31'b0, busy},    {31'b0, e_busy});
        if (wr_uart) n_strobe++;
        if (reset_n && clk_en) begin
            if (m_q.size() != 0) begin
                if (send || (auto_en && display_in != m_snap)) m_pend = 1'b1;
                if (!tx_full) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_last = m_snap;
                end
            end else if (send || (auto_en && display_in != m_last) || m_pend) begin
                m_snap = display_in;
                m_pend = 1'b0;
                build_frame(m_snap);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int base;

    initial begin
        // Reset state
        steps(2);
        reset_n = 1'b1;
        clk_en  = 1'b1;
        steps(2);

        // Single frame, no stalls
        display_in = 16'h1A2F;
        base = n_strobe;
        send = 1'b1; step(); send = 1'b0;
        steps(FRAME_LEN + 2);
        check_value("t1_frame_len", n_strobe - base, FRAME_LEN);

        // Same frame with the FIFO full for 5 cycles after byte 2
        base = n_strobe;
        send = 1'b1; step(); send = 1'b0;
        steps(2);
        tx_full = 1'b1; steps(5); tx_full = 1'b0;
        steps(FRAME_LEN);
        check_value("t2_frame_len", n_strobe - base, FRAME_LEN);

        // Auto mode: change 0000 -> 00FF yields one frame, holding yields none
        auto_en = 1'b1;
        display_in = 16'h0000;
        steps(FRAME_LEN + 3);
        display_in = 16'h00FF;
        base = n_strobe;
        steps(FRAME_LEN + 3);
        check_value("t3_one_frame", n_strobe - base, FRAME_LEN);
        base = n_strobe;
        steps(12);
        check_value("t3_quiet", n_strobe - base, 0);
        auto_en = 1'b0;

        // Requests while busy coalesce into one extra frame with the new value
        display_in = 16'h1234;
        base = n_strobe;
        send = 1'b1; step(); send = 1'b0;
        step();
        send = 1'b1; step(); send = 1'b0;
        display_in = 16'hBEEF;
        step();
        send = 1'b1; step(); send = 1'b0;
        step();
        send = 1'b1; step(); send = 1'b0;
        steps(2 * FRAME_LEN + 4);
        check_value("t4_two_frames", n_strobe - base, 2 * FRAME_LEN);

        // Reset mid-frame after the 3rd byte, then a clean frame
        send = 1'b1; step(); send = 1'b0;
        steps(3);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        base = n_strobe;
        steps(3);
        check_value("t5_abandoned", n_strobe - base, 0);
        send = 1'b1; step(); send = 1'b0;
        steps(FRAME_LEN + 2);
        check_value("t5_frame_len", n_strobe - base, FRAME_LEN);

        // clk_en toggling stretches a frame without extra/missing strobes
        display_in = 16'h0009;
        base = n_strobe;
        send = 1'b1; step(); send = 1'b0;
        for (int i = 0; i < 3 * FRAME_LEN; i++) begin
            clk_en = (i % 3 != 1);
            step();
        end
        clk_en = 1'b1;
        steps(4);
        check_value("t6_frame_len", n_strobe - base, FRAME_LEN);

        // Send in the same cycle LF is accepted starts a frame after one IDLE
        base = n_strobe;
        send = 1'b1; step(); send = 1'b0;
        steps(FRAME_LEN - 1);
        send = 1'b1; step(); send = 1'b0;
        steps(FRAME_LEN + 3);
        check_value("t7_back_to_back", n_strobe - base, 2 * FRAME_LEN);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            clk_en  = ($urandom % 8) != 0;
            tx_full = ($urandom % 5) == 0;
            send    = ($urandom % 20) == 0;
            if ((i % 400) == 0) auto_en = $urandom % 2;
            if (($urandom % 25) == 0) begin
                case ($urandom % 4)
                    0:       display_in = 16'h0000;
                    1:       display_in = 16'hFFFF;
                    default: display_in = 16'($urandom);
                endcase
            end
            reset_n = ($urandom % 600) != 0;
            step();
            reset_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
